// File: rtl/sample_jitter_pkg.sv
// Shared constants for the sample jitter unit: coordinate defaults, hash slice, jitter field split.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sample_jitter_pkg;

  // Default fixed-point format of sample coordinates.
  localparam int SIGFIG_DEF = 24;
  localparam int RADIX_DEF  = 10;
  localparam int TAG_W_DEF  = 16;

  // Hash folds {x[19:0], y[19:0]} down to one byte.
  localparam int HASH_SLICE_HI = 19;
  localparam int HASH_SLICE_LO = 0;
  localparam int HASH_IN_W     = 2 * (HASH_SLICE_HI - HASH_SLICE_LO + 1);
  localparam int HASH_OUT_W    = 8;

  // Hash byte splits into a 4-bit X offset (upper) and a 4-bit Y offset (lower).
  localparam int JIT_W = 4;

  localparam logic [HASH_OUT_W-1:0] HASH_MASK_ON  = 8'hFF;
  localparam logic [HASH_OUT_W-1:0] HASH_MASK_OFF = 8'h00;

  // Disabling jitter forces the hash, and therefore both offsets, to zero.
  function automatic logic [HASH_OUT_W-1:0] hash_mask(input logic jitter_en);
    return jitter_en ? HASH_MASK_ON : HASH_MASK_OFF;
  endfunction

endpackage

// File: rtl/tree_hash.sv
// XOR-tree hash: input bit i is folded into output bit (i mod OUT_WIDTH), result ANDed with a mask.
// Latency: combinational.
// Backpressure: none (pure function).
//
// Ports: in_dat (IN_WIDTH) hash key, mask_dat (OUT_WIDTH) output mask, hash_dat (OUT_WIDTH) result.
module tree_hash #(
  parameter int IN_WIDTH  = 40,
  parameter int OUT_WIDTH = 8
) (
  input  logic [IN_WIDTH-1:0]  in_dat,
  input  logic [OUT_WIDTH-1:0] mask_dat,
  output logic [OUT_WIDTH-1:0] hash_dat
);

  logic [OUT_WIDTH-1:0] fold;

  always_comb begin
    fold = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      fold[i % OUT_WIDTH] = fold[i % OUT_WIDTH] ^ in_dat[i];
    end
  end

  assign hash_dat = fold & mask_dat;

endmodule

// File: rtl/sample_jitter.sv
// Two-stage jitter pipe: S1 captures sample + config, S2 registers position + hashed sub-sample offset.
// Latency: 2 cycles, 1 sample/cycle when downstream is not stalling.
// Backpressure: valid/halt with bubble collapsing; halt_out_RnnL is combinational from halt_in_RnnL.
//
// Ports: clk, rst (async active-low); upstream valid_in/x_in/y_in/tag_in/jitter_en/ss_lg2 and
// halt_out (low = stall); downstream valid_out/x_out/y_out/tag_out and halt_in (low = stall).
module sample_jitter
  import sample_jitter_pkg::*;
#(
  parameter int SIGFIG = SIGFIG_DEF,
  parameter int RADIX  = RADIX_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in_RnnH,
  input  logic [SIGFIG-1:0] x_in_RnnU,
  input  logic [SIGFIG-1:0] y_in_RnnU,
  input  logic [TAG_W-1:0]  tag_in_RnnH,
  input  logic              jitter_en_RnnH,
  input  logic [1:0]        ss_lg2_RnnU,
  output logic              halt_out_RnnL,
  output logic              valid_out_RnnH,
  output logic [SIGFIG-1:0] x_out_RnnU,
  output logic [SIGFIG-1:0] y_out_RnnU,
  output logic [TAG_W-1:0]  tag_out_RnnH,
  input  logic              halt_in_RnnL
);

  // Stage 1: raw sample plus the config it was issued under.
  logic              v1_q, v1_d;
  logic [SIGFIG-1:0] x1_q, x1_d;
  logic [SIGFIG-1:0] y1_q, y1_d;
  logic [TAG_W-1:0]  tag1_q, tag1_d;
  logic              jen1_q, jen1_d;
  logic [1:0]        ss1_q, ss1_d;

  // Stage 2: jittered sample presented downstream.
  logic              v2_q, v2_d;
  logic [SIGFIG-1:0] x2_q, x2_d;
  logic [SIGFIG-1:0] y2_q, y2_d;
  logic [TAG_W-1:0]  tag2_q, tag2_d;

  logic adv1, adv2;

  // A stage advances when empty or when the stage after it advances.
  assign adv2 = !v2_q || halt_in_RnnL;
  assign adv1 = !v1_q || adv2;

  // Offset datapath between S1 and S2.
  logic [HASH_IN_W-1:0]  hash_key;
  logic [HASH_OUT_W-1:0] hash;
  logic [JIT_W-1:0]      jx, jy;
  logic [RADIX-1:0]      off_x_frac, off_y_frac;
  logic [SIGFIG-1:0]     off_x, off_y;

  assign hash_key = {x1_q[HASH_SLICE_HI:HASH_SLICE_LO], y1_q[HASH_SLICE_HI:HASH_SLICE_LO]};

  tree_hash #(
    .IN_WIDTH  (HASH_IN_W),
    .OUT_WIDTH (HASH_OUT_W)
  ) u_tree_hash (
    .in_dat   (hash_key),
    .mask_dat (hash_mask(jen1_q)),
    .hash_dat (hash)
  );

  assign jx = hash[HASH_OUT_W-1 -: JIT_W];
  assign jy = hash[JIT_W-1:0];

  // The 4-bit jitter is the top of a one-pixel fraction; finer sub-sample grids shrink it.
  assign off_x_frac = {jx, {(RADIX-JIT_W){1'b0}}} >> ss1_q;
  assign off_y_frac = {jy, {(RADIX-JIT_W){1'b0}}} >> ss1_q;
  assign off_x      = {{(SIGFIG-RADIX){1'b0}}, off_x_frac};
  assign off_y      = {{(SIGFIG-RADIX){1'b0}}, off_y_frac};

  always_comb begin
    v1_d   = v1_q;
    x1_d   = x1_q;
    y1_d   = y1_q;
    tag1_d = tag1_q;
    jen1_d = jen1_q;
    ss1_d  = ss1_q;
    v2_d   = v2_q;
    x2_d   = x2_q;
    y2_d   = y2_q;
    tag2_d = tag2_q;

    if (adv1) begin
      v1_d   = valid_in_RnnH;
      x1_d   = x_in_RnnU;
      y1_d   = y_in_RnnU;
      tag1_d = tag_in_RnnH;
      jen1_d = jitter_en_RnnH;
      ss1_d  = ss_lg2_RnnU;
    end

    if (adv2) begin
      v2_d   = v1_q;
      x2_d   = x1_q + off_x;   // wraps modulo 2^SIGFIG
      y2_d   = y1_q + off_y;
      tag2_d = tag1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q   <= 1'b0;
      x1_q   <= '0;
      y1_q   <= '0;
      tag1_q <= '0;
      jen1_q <= 1'b0;
      ss1_q  <= '0;
      v2_q   <= 1'b0;
      x2_q   <= '0;
      y2_q   <= '0;
      tag2_q <= '0;
    end else begin
      v1_q   <= v1_d;
      x1_q   <= x1_d;
      y1_q   <= y1_d;
      tag1_q <= tag1_d;
      jen1_q <= jen1_d;
      ss1_q  <= ss1_d;
      v2_q   <= v2_d;
      x2_q   <= x2_d;
      y2_q   <= y2_d;
      tag2_q <= tag2_d;
    end
  end

  assign halt_out_RnnL  = adv1;
  assign valid_out_RnnH = v2_q;
  assign x_out_RnnU     = x2_q;
  assign y_out_RnnU     = y2_q;
  assign tag_out_RnnH   = tag2_q;

endmodule

// File: tb/tb_sample_jitter.sv
// Bench for sample_jitter: directed vector table, backpressure and reset sequences, random traffic.
// Latency: n/a.
// Backpressure: drives halt_in_RnnL from the sequences and randomly.
module tb_sample_jitter;

  logic        clk;
  logic        rst;
  logic        valid_in_RnnH;
  logic [23:0] x_in_RnnU, y_in_RnnU;
  logic [15:0] tag_in_RnnH;
  logic        jitter_en_RnnH;
  logic [1:0]  ss_lg2_RnnU;
  logic        halt_out_RnnL;
  logic        valid_out_RnnH;
  logic [23:0] x_out_RnnU, y_out_RnnU;
  logic [15:0] tag_out_RnnH;
  logic        halt_in_RnnL;

  sample_jitter #(.SIGFIG(24), .RADIX(10), .TAG_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in_RnnH  (valid_in_RnnH),
    .x_in_RnnU      (x_in_RnnU),
    .y_in_RnnU      (y_in_RnnU),
    .tag_in_RnnH    (tag_in_RnnH),
    .jitter_en_RnnH (jitter_en_RnnH),
    .ss_lg2_RnnU    (ss_lg2_RnnU),
    .halt_out_RnnL  (halt_out_RnnL),
    .valid_out_RnnH (valid_out_RnnH),
    .x_out_RnnU     (x_out_RnnU),
    .y_out_RnnU     (y_out_RnnU),
    .tag_out_RnnH   (tag_out_RnnH),
    .halt_in_RnnL   (halt_in_RnnL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: fold the 40-bit key byte by byte, split into nibbles, scale to a pixel fraction.
  function automatic logic [47:0] model_xy(input logic [23:0] x, input logic [23:0] y,
                                           input logic jen, input logic [1:0] ss);
    longint unsigned key, h, ox, oy, rx, ry;
    key = (longint'(x) % 64'd1048576) * 64'd1048576 + (longint'(y) % 64'd1048576);
    h = 0;
    for (int k = 0; k < 5; k++) h = h ^ ((key / (64'd1 << (8 * k))) % 64'd256);
    if (!jen) h = 0;
    ox = ((h / 16) * 64) / (64'd1 << ss);
    oy = ((h % 16) * 64) / (64'd1 << ss);
    rx = (longint'(x) + ox) % 64'd16777216;
    ry = (longint'(y) + oy) % 64'd16777216;
    return {rx[23:0], ry[23:0]};
  endfunction

  // Scoreboard of accepted samples in order: {tag, x, y}.
  logic [63:0] sbq[$];

  always @(negedge rst) sbq.delete();

  always @(negedge clk) begin
    if (rst) begin
      logic [47:0] m;
      // Stall upstream exactly when two samples are in flight and downstream stalls.
      chk("halt_out", halt_out_RnnL, !(sbq.size() == 2 && !halt_in_RnnL));
      chk("spurious_valid", valid_out_RnnH && (sbq.size() == 0), 0);
      if (valid_out_RnnH && sbq.size() != 0) begin
        chk("stream_out", {tag_out_RnnH, x_out_RnnU, y_out_RnnU}, sbq[0]);
        if (halt_in_RnnL) void'(sbq.pop_front());
      end
      if (valid_in_RnnH && halt_out_RnnL) begin
        m = model_xy(x_in_RnnU, y_in_RnnU, jitter_en_RnnH, ss_lg2_RnnU);
        sbq.push_back({tag_in_RnnH, m});
      end
    end
  end

  task automatic drive(input logic v, input logic [23:0] x, input logic [23:0] y,
                       input logic [15:0] tag, input logic jen, input logic [1:0] ss);
    valid_in_RnnH  = v;
    x_in_RnnU      = x;
    y_in_RnnU      = y;
    tag_in_RnnH    = tag;
    jitter_en_RnnH = jen;
    ss_lg2_RnnU    = ss;
  endtask

  typedef struct {
    logic [23:0] x;
    logic [23:0] y;
    logic [15:0] tag;
    logic        jen;
    logic [1:0]  ss;
    logic [23:0] ex;
    logic [23:0] ey;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int sent, cons, first_after, last_after, n_after;

    vecs[0] = '{24'h000000, 24'h0000A5, 16'h1111, 1'b1, 2'd0, 24'h000280, 24'h0001E5};
    vecs[1] = '{24'h000000, 24'h0000A5, 16'h2222, 1'b1, 2'd2, 24'h0000A0, 24'h0000F5};
    vecs[2] = '{24'h000000, 24'h0000A5, 16'h3333, 1'b0, 2'd0, 24'h000000, 24'h0000A5};
    vecs[3] = '{24'hFFFFFF, 24'h000000, 16'h4444, 1'b1, 2'd0, 24'h0003BF, 24'h000000};
    vecs[4] = '{24'h000000, 24'h0000A5, 16'h5555, 1'b1, 2'd3, 24'h000050, 24'h0000CD};
    vecs[5] = '{24'h000000, 24'h0000A5, 16'h6666, 1'b1, 2'd1, 24'h000140, 24'h000145};
    vecs[6] = '{24'h000000, 24'hFFFFFF, 16'h7777, 1'b1, 2'd0, 24'h000000, 24'h0003BF};
    vecs[7] = '{24'hF00000, 24'h0000A5, 16'h8888, 1'b1, 2'd0, 24'hF00280, 24'h0001E5};

    rst = 1'b0;
    halt_in_RnnL = 1'b1;
    drive(1'b0, 24'h0, 24'h0, 16'h0, 1'b0, 2'd0);

    // Outputs while held in reset.
    #12;
    chk("rst_valid_out", valid_out_RnnH, 0);
    chk("rst_halt_out", halt_out_RnnL, 1);
    chk("rst_x_out", x_out_RnnU, 0);
    chk("rst_y_out", y_out_RnnU, 0);
    chk("rst_tag_out", tag_out_RnnH, 0);
    #10 rst = 1'b1;   // t=22, between edges

    // Directed vectors: one sample at a time, check 2-cycle latency and result.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(1'b1, vecs[i].x, vecs[i].y, vecs[i].tag, vecs[i].jen, vecs[i].ss);
      @(posedge clk); #1;
      drive(1'b0, 24'h0, 24'h0, 16'h0, 1'b0, 2'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_lat1_valid", i), valid_out_RnnH, 0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), valid_out_RnnH, 1);
      chk($sformatf("vec%0d_x", i), x_out_RnnU, vecs[i].ex);
      chk($sformatf("vec%0d_y", i), y_out_RnnU, vecs[i].ey);
      chk($sformatf("vec%0d_tag", i), tag_out_RnnH, vecs[i].tag);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_consumed", i), valid_out_RnnH, 0);
    end

    // Backpressure: 10 back-to-back samples, downstream stalls in cycles 3..7.
    sent = 0; cons = 0; first_after = -1; last_after = -1; n_after = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      halt_in_RnnL = !(c >= 3 && c <= 7);
      if (sent < 10)
        drive(1'b1, 24'(sent * 24'h123), 24'(sent * 24'h4567), 16'(16'h0100 + sent), 1'b1, 2'(sent));
      else
        drive(1'b0, 24'h0, 24'h0, 16'h0, 1'b0, 2'd0);
      @(negedge clk);
      if (valid_in_RnnH && halt_out_RnnL) sent++;
      if (valid_out_RnnH && halt_in_RnnL) begin
        cons++;
        if (c >= 8) begin
          if (first_after < 0) first_after = c;
          last_after = c;
          n_after++;
        end
      end
    end
    chk("bp_sent", sent, 10);
    chk("bp_consumed", cons, 10);
    chk("bp_resume_cycle", first_after, 8);
    chk("bp_no_bubbles", last_after - first_after + 1, n_after);

    // Reset with both stages full and downstream stalled.
    @(posedge clk); #1;
    halt_in_RnnL = 1'b0;
    drive(1'b1, 24'h000100, 24'h000200, 16'hAAAA, 1'b1, 2'd0);
    @(posedge clk); #1;
    drive(1'b1, 24'h000300, 24'h000400, 16'hBBBB, 1'b1, 2'd1);
    @(posedge clk); #1;
    drive(1'b1, 24'h000500, 24'h000600, 16'hCCCC, 1'b1, 2'd2);
    @(negedge clk);
    chk("full_halt_out", halt_out_RnnL, 0);
    chk("full_valid_out", valid_out_RnnH, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid_out", valid_out_RnnH, 0);
    chk("midrst_halt_out", halt_out_RnnL, 1);
    chk("midrst_tag_out", tag_out_RnnH, 0);
    drive(1'b0, 24'h0, 24'h0, 16'h0, 1'b0, 2'd0);
    halt_in_RnnL = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 24'h000000, 24'h0000A5, 16'hD00D, 1'b1, 2'd0);
    @(posedge clk); #1;
    drive(1'b0, 24'h0, 24'h0, 16'h0, 1'b0, 2'd0);
    @(negedge clk);
    chk("postrst_lat1_valid", valid_out_RnnH, 0);
    @(posedge clk);
    @(negedge clk);
    chk("postrst_valid", valid_out_RnnH, 1);
    chk("postrst_tag", tag_out_RnnH, 16'hD00D);
    chk("postrst_x", x_out_RnnU, 24'h000280);
    chk("postrst_y", y_out_RnnU, 24'h0001E5);

    // Random traffic against the scoreboard.
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      halt_in_RnnL = ($urandom_range(3) != 0);
      drive($urandom_range(2) != 0, 24'($urandom), 24'($urandom), 16'($urandom),
            1'($urandom), 2'($urandom));
    end
    @(posedge clk); #1;
    halt_in_RnnL = 1'b1;
    drive(1'b0, 24'h0, 24'h0, 16'h0, 1'b0, 2'd0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", sbq.size(), 0);
    chk("drain_valid_out", valid_out_RnnH, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_jitter.md
# sample_jitter

Two-stage pipelined jitter unit that consumes raw sample coordinates and emits hash-jittered sample positions to the sample test stage. It applies the team's 40→8 XOR-tree hash to each sample's coordinates and splits the hash into X/Y sub-sample offsets. It scales the offsets by the current sub-sample size, adds them to the position, and passes the result downstream. Valid/halt handshake on both sides with bubble collapsing. Sits between the sample iterator and the sample test pipeline.

## Interface
- SIGFIG, 24, width of fixed-point coordinates
- RADIX, 10, fractional bits of coordinates (pixel = 1 << RADIX)
- TAG_W, 16, width of opaque sideband carried with each sample
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- valid_in_RnnH  in  1  upstream sample valid
- x_in_RnnU, y_in_RnnU  in  SIGFIG each  sample position
- tag_in_RnnH  in  TAG_W  sideband, passed unchanged
- jitter_en_RnnH  in  1  config: 1 = jitter enabled
- ss_lg2_RnnU  in  2  config: log2 of sub-samples per pixel edge (0..3)
- halt_out_RnnL  out  1  to upstream, low = stall (do not present new sample)
- valid_out_RnnH  out  1  downstream sample valid
- x_out_RnnU, y_out_RnnU  out  SIGFIG each  jittered position
- tag_out_RnnH  out  TAG_W  sideband
- halt_in_RnnL  in  1  from downstream, low = stall

## Operation
- Stage 1 (S1) captures valid, x, y, tag, jitter_en and ss_lg2 from the inputs. Config is sampled per sample, so config changes never corrupt in-flight samples.
- Hash input is {x[19:0], y[19:0]}, 40 bits. Hash mask is 8'hFF when the captured jitter_en = 1, else 8'h00. Output is hash[7:0].
- jx = hash[7:4]; jy = hash[3:0].
- off_x = ({jx, (RADIX-4)'b0}) >> ss_lg2. off_y is formed the same way from jy. Both are zero-extended to SIGFIG.
- Stage 2 (S2) registers x + off_x and y + off_y as unsigned SIGFIG-bit sums. Carries beyond bit SIGFIG-1 are dropped, so sums wrap modulo 2^SIGFIG. S2 also registers the tag.
- Advance rules, bubble collapsing:
  - adv2 = !v2 | halt_in_RnnL
  - adv1 = !v1 | adv2
- On adv2, S2 loads from S1 and v2 takes the value of v1. On adv1, S1 loads from the inputs and v1 takes the value of valid_in.
- halt_out_RnnL = adv1. This is a combinational path from halt_in_RnnL.
- Data registers hold their value when their stage is not advancing. Data in invalid stages is don't-care for verification but must not be X after reset.

## Timing
- Reset (rst low, asynchronous): v1 = v2 = 0; all data registers = 0.
- Outputs during reset: valid_out_RnnH = 0; x_out, y_out, tag_out = 0; halt_out_RnnL = 1.
- Latency is 2 cycles. A sample accepted at edge N appears at the outputs after edge N+1 and is consumed at edge N+2 if halt_in_RnnL = 1.
- Throughput is 1 sample per cycle with no bubbles while halt_in_RnnL = 1.
- When halt_in_RnnL = 0 and v2 = 1: S2 holds and its outputs are stable.
  - If v1 = 0, S1 still accepts one sample, filling the bubble.
  - Once both stages are full, halt_out_RnnL = 0.
- halt_in_RnnL rising with both stages full: S2 drains and S1 shifts in the same cycle, and halt_out_RnnL = 1 in that cycle.
- valid_in_RnnH while halt_out_RnnL = 0 is ignored; upstream must hold the sample.
- Reset asserted mid-stream: all in-flight samples are dropped, with no partial output.

## Structure
- Shared package: SIGFIG/RADIX defaults, the hash input bit-slice positions, and the jitter field split (4 + 4 bits).
- One sub-module: the existing tree_hash (IN_WIDTH=40, OUT_WIDTH=8), instantiated combinationally between S1 and S2.
- Everything else is in this module: two stage registers and the advance logic.

## Test plan
- Reset, then x = 0, y = 24'h0000A5, jitter_en = 1, ss_lg2 = 0. Required: 2 cycles later, x_out = 24'h000280 and y_out = 24'h0001E5.
- Same sample with ss_lg2 = 2. Required: x_out = 24'h0000A0 and y_out = 24'h0000F5.
- Same sample with jitter_en = 0. Required: x_out = 0, y_out = 24'h0000A5, and the tag is unchanged.
- Wrap case: x = 24'hFFFFFF with y chosen so that jx = 4'hF and ss_lg2 = 0. Required: x_out = 24'h0003BF, wrapping modulo 2^24.
- Backpressure: stream 10 samples with halt_in_RnnL low for cycles 3–7.
  - Required: no loss, duplication or reordering of tags.
  - Required: halt_out_RnnL goes low exactly when both stages are valid.
  - Required: 1 sample/cycle once halt_in_RnnL returns high.
- Assert rst low mid-stream with both stages full. Required: valid_out_RnnH = 0 immediately and halt_out_RnnL = 1. After release, the first new sample emerges with 2-cycle latency.
